// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises bitstream words MSB-first into a configuration scan chain.
// Define CCFF_READBACK_EN to add a recirculating readback pass with a parity check.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count,
    output logic              error
);

    localparam int               SUB_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);
    localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SHIFT  = 3'd2,
        VERIFY = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state_r;
    logic [WORD_W-1:0] sreg_r;
    logic [SUB_W-1:0]  sub_cnt_r;
    logic [CNT_W-1:0]  bit_count_r;
    logic              en_r;
    logic              busy_r;
    logic              done_r;

`ifdef CCFF_READBACK_EN
    logic             load_par_r;
    logic             rb_par_r;
    logic             error_r;
    logic [CNT_W-1:0] vcnt_r;

    function automatic logic par_fold(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction
`endif

    // Load sequencer: state, shift register, counters and registered status flags.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_r     <= IDLE;
            sreg_r      <= {WORD_W{1'b0}};
            sub_cnt_r   <= {SUB_W{1'b0}};
            bit_count_r <= {CNT_W{1'b0}};
            en_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef CCFF_READBACK_EN
            load_par_r  <= 1'b0;
            rb_par_r    <= 1'b0;
            error_r     <= 1'b0;
            vcnt_r      <= {CNT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r     <= FETCH;
                        bit_count_r <= {CNT_W{1'b0}};
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
`ifdef CCFF_READBACK_EN
                        load_par_r  <= 1'b0;
                        error_r     <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    if (word_valid) begin
                        sreg_r    <= word_data;
                        sub_cnt_r <= {SUB_W{1'b0}};
                        en_r      <= 1'b1;
                        state_r   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg_r    <= sreg_r << 1;
                    sub_cnt_r <= sub_cnt_r + 1'b1;
                    if (bit_count_r != FULL_CNT) begin
                        bit_count_r <= bit_count_r + 1'b1;
                    end
`ifdef CCFF_READBACK_EN
                    load_par_r <= par_fold(load_par_r, sreg_r[WORD_W-1]);
`endif
                    // Chain full wins over word boundary: leftover word bits are dropped.
                    if (bit_count_r == LAST_BIT) begin
`ifdef CCFF_READBACK_EN
                        state_r  <= VERIFY;
                        vcnt_r   <= {CNT_W{1'b0}};
                        rb_par_r <= 1'b0;
`else
                        state_r  <= DONE;
                        en_r     <= 1'b0;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
`endif
                    end else if (sub_cnt_r == LAST_SUB) begin
                        state_r <= FETCH;
                        en_r    <= 1'b0;
                    end
                end
`ifdef CCFF_READBACK_EN
                VERIFY: begin
                    rb_par_r <= par_fold(rb_par_r, ccff_tail);
                    vcnt_r   <= vcnt_r + 1'b1;
                    if (vcnt_r == LAST_BIT) begin
                        error_r <= load_par_r ^ par_fold(rb_par_r, ccff_tail);
                        state_r <= DONE;
                        en_r    <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_r <= IDLE;
                    en_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign word_ready = (state_r == FETCH);
    assign ccff_en    = en_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign bit_count  = bit_count_r;

`ifdef CCFF_READBACK_EN
    // Recirculate the tail during readback so the chain ends holding its loaded contents.
    assign ccff_head = (state_r == VERIFY) ? ccff_tail : (en_r & sreg_r[WORD_W-1]);
    assign error     = error_r;
`else
    logic unused_tail_s;
    assign unused_tail_s = ccff_tail;
    assign ccff_head     = en_r & sreg_r[WORD_W-1];
    assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader: table-driven loads against a bitstream/chain model,
// plus reset-mid-load and a short-chain instance.
module tb_ccff_chain_loader;

    localparam int CL = 64;
    localparam int WW = 8;
    localparam int CW = $clog2(CL + 1);
`ifdef CCFF_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    typedef struct {
        logic [7:0] pat;
        bit         rand_words;
        int         gap_after;
        int         gap_len;
        bit         rand_valid;
        bit         start_mid;
        bit         do_flip;
        int         exp_cycles;
    } vec_t;

    logic          CK = 1'b0;
    logic          RST, start, word_valid;
    logic [WW-1:0] word_data;
    logic          word_ready, ccff_head, ccff_en, ccff_tail, busy, done, error;
    logic [CW-1:0] bit_count;

    logic          start1, wv1;
    logic [7:0]    wd1;
    logic          ready1, head1, en1, busy1, done1, err1;
    logic [3:0]    bc1;

    logic [CL-1:0] chain = '0;
    logic          flip_now;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CK = ~CK;

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .CK(CK), .RST(RST), .start(start), .word_valid(word_valid), .word_data(word_data),
        .word_ready(word_ready), .ccff_head(ccff_head), .ccff_en(ccff_en), .ccff_tail(ccff_tail),
        .busy(busy), .done(done), .bit_count(bit_count), .error(error)
    );

    ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
        .CK(CK), .RST(RST), .start(start1), .word_valid(wv1), .word_data(wd1),
        .word_ready(ready1), .ccff_head(head1), .ccff_en(en1), .ccff_tail(1'b0),
        .busy(busy1), .done(done1), .bit_count(bc1), .error(err1)
    );

    // Behavioural configuration chain: shifts head in on enabled edges; bit 5 can be upset.
    always @(posedge CK) begin
        if (ccff_en) chain <= {chain[CL-2:0], ccff_head} ^ {{(CL-6){1'b0}}, flip_now, 5'd0};
    end
    assign ccff_tail = chain[CL-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, word_ready, 0);
        chk({tag, "_en"}, ccff_en, 0);
        chk({tag, "_head"}, ccff_head, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_count"}, bit_count, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    task automatic run_load(input vec_t v);
        logic [7:0]    q[$];
        logic [7:0]    w;
        logic [CL-1:0] exp_chain;
        int            popped, en_total, gap_used, done_cyc;
        bit            pending, seen_done;
        for (int i = 0; i < 10; i++) q.push_back(v.rand_words ? 8'($urandom_range(0, 255)) : v.pat);
        // Expected bitstream: words concatenated MSB-first, truncated to the chain length.
        for (int i = 0; i < CL; i++) begin
            w = q[i / WW];
            exp_chain[CL-1-i] = w[WW-1-(i % WW)];
        end
        popped = 0; en_total = 0; gap_used = 0; done_cyc = 0; pending = 0; seen_done = 0;
        @(negedge CK);
        start = 1'b1;
        word_valid = 1'b0;
        for (int cyc = 1; cyc <= 600 && !seen_done; cyc++) begin
            @(negedge CK);
            start = (v.start_mid && cyc == 20) ? 1'b1 : 1'b0;
            flip_now = 1'b0;
            if (pending) popped++;
            if (cyc == 1) begin
                chk("done_drop", done, 0);
                chk("fetch_ready", word_ready, 1);
                chk("busy_on", busy, 1);
            end
            if (ccff_en) begin
                if (en_total < CL) begin
                    chk("bit_count", bit_count, en_total);
                    chk("head", ccff_head, exp_chain[CL-1-en_total]);
                    if (v.do_flip && en_total == CL - 1) flip_now = 1'b1;
                end
                en_total++;
            end
            if (v.gap_len > 0 && popped == v.gap_after && gap_used < v.gap_len && word_ready) begin
                gap_used++;
                chk("gap_en", ccff_en, 0);
                chk("gap_count", bit_count, v.gap_after * WW);
                word_valid = 1'b0;
            end else begin
                word_valid = v.rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            word_data = q[popped];
            pending = word_valid && word_ready;
            if (done) begin
                seen_done = 1;
                done_cyc = cyc;
            end
        end
        chk("done_seen", seen_done, 1);
        if (v.exp_cycles >= 0) chk("done_cycle", done_cyc, v.exp_cycles + RB * CL);
        chk("en_cycles", en_total, CL * (1 + RB));
        chk("final_count", bit_count, CL);
        chk("busy_off", busy, 0);
        chk("error", error, (RB == 1 && v.do_flip) ? 1 : 0);
        if (!v.do_flip) chk("chain", chain, exp_chain);
        word_valid = 1'b1;
        repeat (3) begin
            @(negedge CK);
            if (pending) popped++;
            chk("done_ready", word_ready, 0);
            chk("done_hold", done, 1);
            pending = word_valid && word_ready;
        end
        chk("words_taken", popped, CL / WW);
    endtask

    vec_t       tbl[6];
    logic [7:0] w1[3];

    initial begin
        int idx1, en1_n, ones1;
        bit pend1;
        tbl[0] = '{pat: 8'hA5, rand_words: 0, gap_after: 0, gap_len: 0, rand_valid: 0, start_mid: 0, do_flip: 0, exp_cycles: 73};
        tbl[1] = '{pat: 8'hA5, rand_words: 0, gap_after: 3, gap_len: 5, rand_valid: 0, start_mid: 0, do_flip: 0, exp_cycles: 78};
        tbl[2] = '{pat: 8'h3C, rand_words: 0, gap_after: 0, gap_len: 0, rand_valid: 0, start_mid: 1, do_flip: 0, exp_cycles: 73};
        tbl[3] = '{pat: 8'h00, rand_words: 1, gap_after: 0, gap_len: 0, rand_valid: 1, start_mid: 0, do_flip: 0, exp_cycles: -1};
        tbl[4] = '{pat: 8'h00, rand_words: 1, gap_after: 0, gap_len: 0, rand_valid: 0, start_mid: 0, do_flip: 1, exp_cycles: 73};
        tbl[5] = '{pat: 8'h00, rand_words: 1, gap_after: 0, gap_len: 0, rand_valid: 1, start_mid: 0, do_flip: 0, exp_cycles: -1};
        w1[0] = 8'hFF; w1[1] = 8'hF0; w1[2] = 8'h3C;

        RST = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = 8'h00; flip_now = 1'b0;
        start1 = 1'b0; wv1 = 1'b0; wd1 = 8'h00;
        repeat (3) @(negedge CK);
        chk_idle("reset");
        RST = 1'b0;

        for (int t = 0; t < 6; t++) run_load(tbl[t]);

        // Abandon a load mid-way with reset, then reload from scratch.
        @(negedge CK);
        start = 1'b1; word_valid = 1'b1; word_data = 8'h5A;
        for (int i = 0; i < 200 && bit_count != CW'(30); i++) begin
            @(negedge CK);
            start = 1'b0;
        end
        chk("reach30", bit_count, 30);
        RST = 1'b1;
        @(negedge CK);
        RST = 1'b0;
        chk_idle("midrst");
        @(negedge CK);
        chk("idle_hold", word_ready, 0);
        run_load(tbl[0]);

        // Short chain: second word only partly shifted, third word never taken.
        idx1 = 0; en1_n = 0; ones1 = 0; pend1 = 0;
        @(negedge CK);
        start1 = 1'b1;
        for (int c = 0; c < 100 && !done1; c++) begin
            @(negedge CK);
            start1 = 1'b0;
            if (pend1) idx1++;
            if (en1) begin
                if (en1_n < 12) ones1 += int'(head1);
                en1_n++;
            end
            wv1 = (idx1 < 3);
            wd1 = w1[(idx1 < 3) ? idx1 : 2];
            pend1 = wv1 && ready1;
        end
        chk("s_done", done1, 1);
        chk("s_en_cycles", en1_n, 12 * (1 + RB));
        chk("s_ones", ones1, 12);
        chk("s_count", bc1, 12);
        chk("s_busy", busy1, 0);
        chk("s_error", err1, 0);
        wv1 = 1'b1;
        repeat (3) begin
            @(negedge CK);
            if (pend1) idx1++;
            chk("s_ready", ready1, 0);
            pend1 = wv1 && ready1;
        end
        chk("s_words_taken", idx1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected summary before it");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Sequences bitstream loading into the configuration scan chain (cascaded DFFR configuration flops).
- Accepts parallel bitstream words over a valid/ready handshake and serialises them MSB-first onto the chain head.
- Counts exactly CHAIN_LEN shift pulses, then reports completion.
- Sits between the bitstream source and the fabric's configuration-chain head/tail pins.

Parameters:
- CHAIN_LEN, 64: number of configuration flops in the chain (total bits to shift); must be ≥1.
- WORD_W, 8: bitstream word width; must be ≥1.
- CNT_W, $clog2(CHAIN_LEN+1): derived width of the bit counter; not overridden.

Ports:
- CK  input  1  clock for all state; same clock that drives the chain flops.
- RST  input  1  synchronous, active-high reset.
- start  input  1  pulse to begin a load; sampled only in IDLE or DONE.
- word_valid  input  1  word_data is valid.
- word_data  input  WORD_W  bitstream word, MSB shifted first.
- word_ready  output  1  loader can accept a word this cycle.
- ccff_head  output  1  serial data into the chain head.
- ccff_en  output  1  chain shift enable; the chain advances on the CK edge where this is 1.
- ccff_tail  input  1  serial output of the chain tail.
- busy  output  1  high in FETCH, SHIFT and VERIFY.
- done  output  1  level; high in DONE.
- bit_count  output  CNT_W  bits shifted so far in the current load.
- error  output  1  readback mismatch flag; see Optional Feature.

Behaviour:
- Reset (RST=1 at a CK edge, any state): state=IDLE, word_ready=0, ccff_en=0, ccff_head=0, busy=0, done=0, bit_count=0, error=0, shift register and counters cleared. A reset mid-load abandons the load; the chain contents are undefined and are not repaired.
- States: IDLE, FETCH, SHIFT, VERIFY (macro only), DONE.
- IDLE: start=1 → FETCH; bit_count←0, error←0.
- FETCH:
  - word_ready=1 (combinational from state).
  - On word_valid & word_ready: sreg←word_data, sub-counter←0, go to SHIFT.
  - No other transition; the loader waits indefinitely.
- SHIFT, each cycle:
  - ccff_en=1 and ccff_head=sreg[WORD_W-1].
  - sreg shifts left with 0 fill; sub-counter and bit_count each increment.
  - After the shift that makes bit_count==CHAIN_LEN: go to VERIFY if the macro is defined, else DONE. Any remaining bits of the current word are discarded.
  - Otherwise, after WORD_W shifts: go to FETCH.
- ccff_en=0 and ccff_head=0 in every state except SHIFT and VERIFY.
- DONE:
  - done=1; hold until start=1, then go to FETCH with bit_count←0, done←0, error←0.
  - word_ready=0; extra words presented by the source are not consumed.
- start is ignored in FETCH, SHIFT and VERIFY.
- Throughput: WORD_W+1 cycles per word when word_valid is held high. With the defaults and no macro, start at cycle 0 gives done=1 at cycle 73. There are 64 ccff_en cycles in total.
- bit_count saturates at CHAIN_LEN and never wraps.

Optional Feature:
- Macro: CCFF_READBACK_EN.
- Defined:
  - During SHIFT, a parity register accumulates the XOR of every ccff_head bit driven.
  - VERIFY lasts exactly CHAIN_LEN cycles with ccff_en=1 and ccff_head=ccff_tail (recirculation), so the chain ends holding the loaded contents.
  - ccff_tail is sampled in the same cycle as ccff_en and XORed into a readback parity.
  - On leaving VERIFY: error←(load parity != readback parity), then go to DONE.
  - busy=1 throughout VERIFY; error holds until the next start or RST.
- Undefined: no VERIFY state, no parity logic, error tied to 0.

Test Plan:
- Defaults, word_valid always high, words 0xA5×8, start at cycle 0 → 64 ccff_en cycles; ccff_head sequence 1,0,1,0,0,1,0,1 repeated; done=1 at cycle 73; bit_count=64.
- CHAIN_LEN=12, WORD_W=8, words 0xFF then 0xF0 → 12 ccff_en cycles; head shows 8 ones then 4 ones; the low nibble of 0xF0 is never shifted; done asserts; third offered word is not accepted (word_ready=0).
- word_valid deasserted for 5 cycles between words 3 and 4 → FETCH held, ccff_en=0 during the gap, bit_count frozen at 24; load completes correctly afterwards.
- RST asserted at bit_count=30 → next cycle state IDLE, all outputs 0; a new start reloads from bit_count=0.
- start pulsed during SHIFT → ignored; start in DONE → new load, done drops the following cycle.
- CCFF_READBACK_EN with a behavioural 64-bit chain model → error=0 and chain contents equal the loaded data. Flip one chain bit before VERIFY → error=1 at DONE.
